// File: rtl/poly_est_pkg.sv
// Shared float-datapath types and constants: the IEEE-754 single word, its
// field limits, and the value classes every float consumer branches on.
package poly_est_pkg;

    typedef logic [31:0] float_t;

    localparam int FLOAT_EXP_BIAS  = 127;
    localparam int FLOAT_MANT_BITS = 23;
    localparam int FLOAT_EXP_MAX   = 255;

    typedef enum logic [1:0] {
        FC_ZERO,
        FC_NORM,
        FC_INF,
        FC_NAN
    } float_class_t;

    function automatic float_class_t float_classify(input logic [7:0] exp_f, input logic frac_nz);
        float_class_t c;
        c = FC_NORM;
        if (exp_f == 8'd0)
            c = FC_ZERO;
        else if (exp_f == 8'(FLOAT_EXP_MAX))
            c = frac_nz ? FC_NAN : FC_INF;
        return c;
    endfunction

endpackage

// File: rtl/float_unpack.sv
// Combinational float splitter: sign, biased exponent, 24-bit mantissa with
// the hidden bit restored, and value class. Denormals classify as zero.
module float_unpack
    import poly_est_pkg::*;
(
    input  float_t                   din,
    output logic                     sign,
    output logic [7:0]               exp_f,
    output logic [FLOAT_MANT_BITS:0] mant,
    output float_class_t             fclass
);

    always_comb begin
        sign   = din[31];
        exp_f  = din[30:23];
        mant   = {(din[30:23] != 8'd0), din[FLOAT_MANT_BITS-1:0]};
        fclass = float_classify(din[30:23], |din[FLOAT_MANT_BITS-1:0]);
    end

endmodule

// File: rtl/float_to_fixed_converter.sv
// Three-stage float -> signed fixed-point converter with valid/ready on both
// sides. Optional status outputs (dout_status, sat_count) under FLOAT_TO_FIXED_STATUS_EN.
module float_to_fixed_converter
    import poly_est_pkg::*;
#(
    parameter int G_DWIDTH    = 24,
    parameter int G_FRAC_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  float_t              din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [G_DWIDTH-1:0] dout,
    output logic                dout_valid,
`ifdef FLOAT_TO_FIXED_STATUS_EN
    output logic [1:0]          dout_status,
    output logic [15:0]         sat_count,
`endif
    input  logic                dout_ready
);

    localparam int MW = G_DWIDTH + 25;
    localparam logic [9:0] SH_OFFSET = 10'(G_FRAC_BITS - 150);
    localparam logic [G_DWIDTH-1:0] MAX_POS = {1'b0, {(G_DWIDTH-1){1'b1}}};
    localparam logic [G_DWIDTH-1:0] MIN_NEG = {1'b1, {(G_DWIDTH-1){1'b0}}};

    logic                 active;
    logic                 advance;

    logic                 u_sign;
    logic [7:0]           u_exp;
    logic [23:0]          u_mant;
    float_class_t         u_class;

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_sign_q, s1_sign_d;
    float_class_t         s1_class_q, s1_class_d;
    logic [23:0]          s1_mant_q, s1_mant_d;
    logic signed [9:0]    s1_sh_q, s1_sh_d;

    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_sign_q, s2_sign_d;
    float_class_t         s2_class_q, s2_class_d;
    logic [G_DWIDTH-1:0]  s2_mag_q, s2_mag_d;
    logic                 s2_ovf_q, s2_ovf_d;

    logic                 dout_valid_q, dout_valid_d;
    logic [G_DWIDTH-1:0]  dout_q, dout_d;

    logic [MW-1:0]        wide;
    logic [25:0]          rnd_sum;
    logic [9:0]           neg_sh;
    logic                 ovf_c;
    logic [G_DWIDTH-1:0]  res_c;
`ifdef FLOAT_TO_FIXED_STATUS_EN
    logic                 sat_c, nan_c;
    logic [1:0]           status_q, status_d;
    logic [15:0]          sat_count_q, sat_count_d;
`endif

    assign active     = enable && reset;
    assign advance    = !dout_valid_q || dout_ready;
    assign din_ready  = active && advance;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
`ifdef FLOAT_TO_FIXED_STATUS_EN
    assign dout_status = status_q;
    assign sat_count   = sat_count_q;
`endif

    float_unpack u_unpack (
        .din    (din),
        .sign   (u_sign),
        .exp_f  (u_exp),
        .mant   (u_mant),
        .fclass (u_class)
    );

    // Stage 2 alignment: left shifts that would place the hidden bit at or above
    // G_DWIDTH are overflow outright; right shifts round half away from zero.
    always_comb begin
        wide    = '0;
        rnd_sum = '0;
        neg_sh  = '0;
        ovf_c   = 1'b0;
        if (!s1_sh_q[9]) begin
            if (s1_sh_q >= 10'(G_DWIDTH))
                ovf_c = 1'b1;
            else
                wide = MW'(s1_mant_q) << s1_sh_q[5:0];
        end else begin
            neg_sh = 10'(-s1_sh_q);
            if (neg_sh <= 10'd25) begin
                rnd_sum = {2'b00, s1_mant_q} + (26'd1 << (neg_sh - 10'd1));
                wide    = MW'(rnd_sum >> neg_sh);
            end
        end
        ovf_c = ovf_c || (|wide[MW-1:G_DWIDTH]);
    end

    // Stage 3 sign application and saturation; exactly 2^(W-1) is representable
    // when negative and is not treated as saturation.
    always_comb begin
        res_c = '0;
`ifdef FLOAT_TO_FIXED_STATUS_EN
        sat_c = 1'b0;
        nan_c = (s2_class_q == FC_NAN);
`endif
        case (s2_class_q)
            FC_INF: begin
                res_c = s2_sign_q ? MIN_NEG : MAX_POS;
`ifdef FLOAT_TO_FIXED_STATUS_EN
                sat_c = 1'b1;
`endif
            end
            FC_NORM: begin
                if (!s2_sign_q) begin
                    if (s2_ovf_q || (s2_mag_q > MAX_POS)) begin
                        res_c = MAX_POS;
`ifdef FLOAT_TO_FIXED_STATUS_EN
                        sat_c = 1'b1;
`endif
                    end else begin
                        res_c = s2_mag_q;
                    end
                end else begin
                    if (s2_ovf_q || (s2_mag_q > MIN_NEG)) begin
                        res_c = MIN_NEG;
`ifdef FLOAT_TO_FIXED_STATUS_EN
                        sat_c = 1'b1;
`endif
                    end else begin
                        res_c = -s2_mag_q;
                    end
                end
            end
            default: res_c = '0;
        endcase
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_class_d   = s1_class_q;
        s1_mant_d    = s1_mant_q;
        s1_sh_d      = s1_sh_q;
        s2_valid_d   = s2_valid_q;
        s2_sign_d    = s2_sign_q;
        s2_class_d   = s2_class_q;
        s2_mag_d     = s2_mag_q;
        s2_ovf_d     = s2_ovf_q;
        dout_valid_d = dout_valid_q;
        dout_d       = dout_q;
`ifdef FLOAT_TO_FIXED_STATUS_EN
        status_d     = status_q;
        sat_count_d  = sat_count_q;
`endif
        if (!active) begin
            s1_valid_d   = 1'b0;
            s1_sign_d    = 1'b0;
            s1_class_d   = FC_ZERO;
            s1_mant_d    = '0;
            s1_sh_d      = '0;
            s2_valid_d   = 1'b0;
            s2_sign_d    = 1'b0;
            s2_class_d   = FC_ZERO;
            s2_mag_d     = '0;
            s2_ovf_d     = 1'b0;
            dout_valid_d = 1'b0;
            dout_d       = '0;
`ifdef FLOAT_TO_FIXED_STATUS_EN
            status_d     = 2'b00;
            sat_count_d  = '0;
`endif
        end else if (advance) begin
            s1_valid_d   = din_valid;
            s1_sign_d    = u_sign;
            s1_class_d   = u_class;
            s1_mant_d    = u_mant;
            s1_sh_d      = $signed({2'b00, u_exp} + SH_OFFSET);
            s2_valid_d   = s1_valid_q;
            s2_sign_d    = s1_sign_q;
            s2_class_d   = s1_class_q;
            s2_mag_d     = wide[G_DWIDTH-1:0];
            s2_ovf_d     = ovf_c;
            dout_valid_d = s2_valid_q;
            dout_d       = res_c;
`ifdef FLOAT_TO_FIXED_STATUS_EN
            status_d     = {nan_c, sat_c};
            if (s2_valid_q && sat_c && (sat_count_q != 16'hFFFF))
                sat_count_d = sat_count_q + 16'd1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_class_q   <= FC_ZERO;
            s1_mant_q    <= '0;
            s1_sh_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_class_q   <= FC_ZERO;
            s2_mag_q     <= '0;
            s2_ovf_q     <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
`ifdef FLOAT_TO_FIXED_STATUS_EN
            status_q     <= 2'b00;
            sat_count_q  <= '0;
`endif
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_class_q   <= s1_class_d;
            s1_mant_q    <= s1_mant_d;
            s1_sh_q      <= s1_sh_d;
            s2_valid_q   <= s2_valid_d;
            s2_sign_q    <= s2_sign_d;
            s2_class_q   <= s2_class_d;
            s2_mag_q     <= s2_mag_d;
            s2_ovf_q     <= s2_ovf_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
`ifdef FLOAT_TO_FIXED_STATUS_EN
            status_q     <= status_d;
            sat_count_q  <= sat_count_d;
`endif
        end
    end

endmodule

// File: tb/tb_float_to_fixed_converter.sv
// Bench for float_to_fixed_converter (24-bit, 16 fractional): directed vectors,
// random backpressure against a real-arithmetic reference, and flush behaviour.
module tb_float_to_fixed_converter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [23:0] dout;
    logic        dout_valid;
    logic        dout_ready;
`ifdef FLOAT_TO_FIXED_STATUS_EN
    logic [1:0]  dout_status;
    logic [15:0] sat_count;
    logic [1:0]  got_st_q[$];
`endif

    int total  = 0;
    int passed = 0;

    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];
    logic [23:0] s_dout;
    logic        s_valid, s_din_ready, s_acc, s_out;

    always #5 clk = ~clk;

    float_to_fixed_converter #(.G_DWIDTH(24), .G_FRAC_BITS(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
`ifdef FLOAT_TO_FIXED_STATUS_EN
        .dout_status (dout_status),
        .sat_count   (sat_count),
`endif
        .dout_ready  (dout_ready)
    );

    // Reference: value * 2^16 in real arithmetic, round half away from zero, clamp.
    function automatic logic [23:0] ref_fix(input logic [31:0] f);
        int  e;
        real mag, r;
        e = int'(f[30:23]);
        if (e == 0) return 24'h000000;
        if (e == 255) begin
            if (f[22:0] != 23'd0) return 24'h000000;
            return f[31] ? 24'h800000 : 24'h7FFFFF;
        end
        mag = real'(int'({1'b1, f[22:0]})) * (2.0 ** real'(e - 150 + 16));
        if (mag >= 16777216.0) return f[31] ? 24'h800000 : 24'h7FFFFF;
        r = $floor(mag + 0.5);
        if (!f[31]) begin
            if (r > 8388607.0) return 24'h7FFFFF;
            return 24'(longint'(r));
        end
        if (r > 8388608.0) return 24'h800000;
        return 24'(-longint'(r));
    endfunction

    function automatic logic [31:0] rand_float();
        logic [7:0] e;
        if ($urandom_range(0, 9) == 0)
            e = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd255;
        else
            e = 8'($urandom_range(100, 145));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // One clock: sample at the falling edge, log transfers, return just after the rising edge.
    task automatic step();
        @(negedge clk);
        s_dout      = dout;
        s_valid     = dout_valid;
        s_din_ready = din_ready;
        s_acc       = din_valid && din_ready;
        s_out       = dout_valid && dout_ready;
        if (s_acc) exp_q.push_back(ref_fix(din));
        if (s_out) begin
            got_q.push_back(dout);
`ifdef FLOAT_TO_FIXED_STATUS_EN
            got_st_q.push_back(dout_status);
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        exp_q.delete();
        got_q.delete();
`ifdef FLOAT_TO_FIXED_STATUS_EN
        got_st_q.delete();
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        total++; if (s_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", s_valid); else passed++;
        total++; if (s_dout !== 24'h0) $display("FAIL reset_dout got=%h want=000000", s_dout); else passed++;
        total++; if (s_din_ready !== 1'b0) $display("FAIL reset_din_ready got=%b want=0", s_din_ready); else passed++;
        reset = 1'b1;
        step();
        total++; if (s_din_ready !== 1'b1) $display("FAIL post_reset_din_ready got=%b want=1", s_din_ready); else passed++;
        enable = 1'b0;
        step();
        total++; if (s_din_ready !== 1'b0) $display("FAIL disable_din_ready got=%b want=0", s_din_ready); else passed++;
        enable = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [31:0] vin [2];
        logic [23:0] vexp[2];
        int lat;
        vin[0] = 32'h3FC00000; vexp[0] = 24'h018000;
        vin[1] = 32'hBE800000; vexp[1] = 24'hFFC000;
        for (int i = 0; i < 2; i++) begin
            clear_queues();
            dout_ready = 1'b1;
            din        = vin[i];
            din_valid  = 1'b1;
            step();
            din_valid  = 1'b0;
            total++; if (s_acc !== 1'b1) $display("FAIL basic_accept[%0d] got=%b want=1", i, s_acc); else passed++;
            lat = 0;
            for (int c = 0; c < 10; c++) begin
                step();
                lat++;
                if (s_out) break;
            end
            total++; if (lat !== 3) $display("FAIL basic_latency[%0d] got=%0d want=3", i, lat); else passed++;
            total++;
            if (got_q.size() != 1 || got_q[0] !== vexp[i])
                $display("FAIL basic_value[%0d] got=%h (n=%0d) want=%h", i, (got_q.size() > 0) ? got_q[0] : 24'hx, got_q.size(), vexp[i]);
            else passed++;
            $display("basic din=%h dout=%h latency=%0d", vin[i], s_dout, lat);
        end
    endtask

    task automatic test_specials();
        logic [31:0] vin [10];
        logic [23:0] vexp[10];
        vin[0] = 32'h43480000; vexp[0] = 24'h7FFFFF;
        vin[1] = 32'hC3000000; vexp[1] = 24'h800000;
        vin[2] = 32'hFF800000; vexp[2] = 24'h800000;
        vin[3] = 32'h7FC00000; vexp[3] = 24'h000000;
        vin[4] = 32'h00000001; vexp[4] = 24'h000000;
        vin[5] = 32'h37000000; vexp[5] = 24'h000001;
        vin[6] = 32'hB7000000; vexp[6] = 24'hFFFFFF;
        vin[7] = 32'h36800000; vexp[7] = 24'h000000;
        vin[8] = 32'h7F800000; vexp[8] = 24'h7FFFFF;
        vin[9] = 32'h80000000; vexp[9] = 24'h000000;
        clear_queues();
        dout_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din       = vin[i];
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        for (int c = 0; c < 20 && got_q.size() < 10; c++) step();
        total++; if (got_q.size() != 10) $display("FAIL specials_count got=%0d want=10", got_q.size()); else passed++;
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== vexp[i]) $display("FAIL special[%0d] din=%h got=%h want=%h", i, vin[i], got_q[i], vexp[i]);
            else passed++;
            $display("special din=%h dout=%h", vin[i], got_q[i]);
        end
    endtask

    task automatic test_back_to_back_backpressure();
        logic [31:0] vals[8];
        logic [23:0] prev_dout;
        logic        prev_stall;
        int          idx;
        for (int i = 0; i < 8; i++) vals[i] = rand_float();
        clear_queues();
        idx        = 0;
        prev_stall = 1'b0;
        prev_dout  = '0;
        for (int c = 0; c < 300 && (idx < 8 || got_q.size() < 8); c++) begin
            din_valid  = (idx < 8) && ($urandom_range(0, 3) != 0);
            din        = (idx < 8) ? vals[idx] : 32'h0;
            dout_ready = 1'($urandom_range(0, 1));
            step();
            if (s_acc) idx++;
            total++;
            if (s_din_ready !== !(s_valid && !dout_ready))
                $display("FAIL bp_din_ready cyc=%0d got=%b want=%b", c, s_din_ready, !(s_valid && !dout_ready));
            else passed++;
            if (prev_stall) begin
                total++;
                if (s_valid !== 1'b1 || s_dout !== prev_dout)
                    $display("FAIL bp_stable cyc=%0d got=%b/%h want=1/%h", c, s_valid, s_dout, prev_dout);
                else passed++;
            end
            prev_stall = s_valid && !dout_ready;
            prev_dout  = s_dout;
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        total++;
        if (got_q.size() != 8 || exp_q.size() != 8)
            $display("FAIL bp_count got=%0d want=8 (accepted=%0d)", got_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < 8 && i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL bp_value[%0d] din=%h got=%h want=%h", i, vals[i], got_q[i], exp_q[i]);
            else passed++;
            $display("bp din=%h dout=%h", vals[i], got_q[i]);
        end
    endtask

    task automatic test_flush(input bit use_enable);
        int seen;
        clear_queues();
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din       = rand_float();
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        total++; if (exp_q.size() != 3) $display("FAIL flush_accept[%0d] got=%0d want=3", use_enable, exp_q.size()); else passed++;
        if (use_enable) enable = 1'b0; else reset = 1'b0;
        step();
        total++; if (s_valid !== 1'b1) $display("FAIL flush_inflight[%0d] got=%b want=1", use_enable, s_valid); else passed++;
        enable = 1'b1;
        reset  = 1'b1;
        dout_ready = 1'b1;
        step();
        total++; if (s_valid !== 1'b0) $display("FAIL flush_next_valid[%0d] got=%b want=0", use_enable, s_valid); else passed++;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (s_valid) seen++;
        end
        total++; if (seen != 0) $display("FAIL flush_leak[%0d] got=%0d want=0", use_enable, seen); else passed++;
        din       = 32'h3FC00000;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int c = 0; c < 10 && got_q.size() < 1; c++) step();
        total++;
        if (got_q.size() != 1 || got_q[0] !== 24'h018000)
            $display("FAIL flush_recover[%0d] got=%h (n=%0d) want=018000", use_enable, (got_q.size() > 0) ? got_q[0] : 24'hx, got_q.size());
        else passed++;
        $display("flush mode=%0d leaked=%0d recovered_n=%0d", use_enable, seen, got_q.size());
    endtask

`ifdef FLOAT_TO_FIXED_STATUS_EN
    task automatic test_status();
        logic [31:0] vin[4];
        logic [1:0]  vst[4];
        vin[0] = 32'h43480000; vst[0] = 2'b01;
        vin[1] = 32'hFF800000; vst[1] = 2'b01;
        vin[2] = 32'h7F800000; vst[2] = 2'b01;
        vin[3] = 32'h7FC00000; vst[3] = 2'b10;
        reset = 1'b0;
        step();
        reset = 1'b1;
        clear_queues();
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din       = vin[i];
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        for (int c = 0; c < 10 && got_st_q.size() < 4; c++) step();
        total++; if (got_st_q.size() != 4) $display("FAIL status_count got=%0d want=4", got_st_q.size()); else passed++;
        for (int i = 0; i < 4 && i < got_st_q.size(); i++) begin
            total++;
            if (got_st_q[i] !== vst[i]) $display("FAIL status[%0d] got=%b want=%b", i, got_st_q[i], vst[i]);
            else passed++;
            $display("status din=%h st=%b", vin[i], got_st_q[i]);
        end
        total++; if (sat_count !== 16'd3) $display("FAIL sat_count got=%0d want=3", sat_count); else passed++;
    endtask
`endif

    initial begin
        reset      = 1'b0;
        enable     = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        test_reset();
        test_basic();
        test_specials();
        test_back_to_back_backpressure();
        test_flush(1'b0);
        test_flush(1'b1);
`ifdef FLOAT_TO_FIXED_STATUS_EN
        test_status();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
